// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : MM:SS BCD time-keeping core with run/pause and adjust modes.
//               Counts rising edges of the 1 Hz tick, steps the selected field
//               on the adjust tick, and drives registered per-field blank flags
//               for the display driver.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       onehz_clk,
    input  logic       twohz_clk,
    input  logic       blink_clk,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       blank_min,
    output logic       blank_sec
);

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_pause  = 2'd1;
    localparam logic [1:0] c_st_adjust = 2'd2;

    localparam logic [3:0] c_min_tens_max = 4'(MAX_MIN / 10);
    localparam logic [3:0] c_min_ones_max = 4'(MAX_MIN % 10);
    localparam logic [3:0] c_sec_tens_max = 4'(MAX_SEC / 10);
    localparam logic [3:0] c_sec_ones_max = 4'(MAX_SEC % 10);

    logic [1:0] r_state;
    logic       r_paused;
    logic       r_prev1;
    logic       r_prev2;
    logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic       r_blank_min, r_blank_sec;

    logic       w_tick1, w_tick2;
    logic [1:0] w_next_state;
    logic       w_next_paused;
    logic       w_run_tick;
    logic       w_adj_tick;
    logic       w_sec_at_max;
    logic [7:0] w_sec_inc, w_min_inc;

    // Increment a two-digit BCD field, wrapping from its maximum to 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [3:0] max_tens, input logic [3:0] max_ones);
        if (tens == max_tens && ones == max_ones)
            return 8'h00;
        else if (ones == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    // A tick is a genuine 0->1 transition seen against the previous sample.
    assign w_tick1 = onehz_clk & ~r_prev1;
    assign w_tick2 = twohz_clk & ~r_prev2;

    assign w_sec_inc    = bcd_inc(r_sec_tens, r_sec_ones, c_sec_tens_max, c_sec_ones_max);
    assign w_min_inc    = bcd_inc(r_min_tens, r_min_ones, c_min_tens_max, c_min_ones_max);
    assign w_sec_at_max = (r_sec_tens == c_sec_tens_max) && (r_sec_ones == c_sec_ones_max);

    // Mode transitions and which tick (if any) is honoured this cycle.
    always_comb begin
        w_next_state  = r_state;
        w_next_paused = r_paused;
        w_run_tick    = 1'b0;
        w_adj_tick    = 1'b0;
        case (r_state)
            c_st_run: begin
                if (adj) begin
                    // Entering adjust drops the count tick but keeps an adjust tick.
                    w_next_state  = c_st_adjust;
                    w_next_paused = r_paused ^ pause_p;
                    w_adj_tick    = w_tick2;
                end else if (pause_p) begin
                    // Tick arriving with the pause pulse still counts.
                    w_next_state  = c_st_pause;
                    w_next_paused = 1'b1;
                    w_run_tick    = w_tick1;
                end else begin
                    w_run_tick    = w_tick1;
                end
            end
            c_st_pause: begin
                if (adj) begin
                    w_next_state  = c_st_adjust;
                    w_next_paused = r_paused ^ pause_p;
                    w_adj_tick    = w_tick2;
                end else if (pause_p) begin
                    w_next_state  = c_st_run;
                    w_next_paused = 1'b0;
                end
            end
            c_st_adjust: begin
                // Pause pulses only flip the remembered run/pause choice here.
                w_next_paused = r_paused ^ pause_p;
                if (!adj) begin
                    w_next_state = w_next_paused ? c_st_pause : c_st_run;
                    w_run_tick   = w_tick1 & ~w_next_paused;
                end else begin
                    w_adj_tick   = w_tick2;
                end
            end
            default: begin
                w_next_state  = c_st_run;
                w_next_paused = 1'b0;
            end
        endcase
    end

    // State, edge-detect history and the paused flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_run;
            r_paused <= 1'b0;
            r_prev1  <= 1'b1;
            r_prev2  <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_paused <= w_next_paused;
            r_prev1  <= onehz_clk;
            r_prev2  <= twohz_clk;
        end
    end

    // Digit update: carrying run count, or non-carrying single-field adjust.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else if (w_run_tick) begin
            {r_sec_tens, r_sec_ones} <= w_sec_inc;
            if (w_sec_at_max)
                {r_min_tens, r_min_ones} <= w_min_inc;
        end else if (w_adj_tick) begin
            if (sel)
                {r_sec_tens, r_sec_ones} <= w_sec_inc;
            else
                {r_min_tens, r_min_ones} <= w_min_inc;
        end
    end

    // Blink the field under adjustment; one cycle behind blink/sel/state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_blank_min <= (r_state == c_st_adjust) & ~sel & blink_clk;
            r_blank_sec <= (r_state == c_st_adjust) &  sel & blink_clk;
        end
    end

    assign min_tens  = r_min_tens;
    assign min_ones  = r_min_ones;
    assign sec_tens  = r_sec_tens;
    assign sec_ones  = r_sec_ones;
    assign paused    = r_paused;
    assign blank_min = r_blank_min;
    assign blank_sec = r_blank_sec;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed bench for stopwatch_counter. Stimulus pushes the
//               expected display state into a scoreboard queue; a monitor on
//               the falling clock edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       onehz_clk = 1'b0;
    logic       twohz_clk = 1'b0;
    logic       blink_clk = 1'b0;
    logic       pause_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, blank_min, blank_sec;

    stopwatch_counter #(.MAX_MIN(59), .MAX_SEC(59)) dut (
        .clk       (clk),
        .rst       (rst),
        .onehz_clk (onehz_clk),
        .twohz_clk (twohz_clk),
        .blink_clk (blink_clk),
        .pause_p   (pause_p),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .paused    (paused),
        .blank_min (blank_min),
        .blank_sec (blank_sec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] dig;
        logic        p;
        logic        bm;
        logic        bs;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the state the DUT must show at the coming falling edge.
    task automatic expect_st(input string name, input int mm, input int ss,
                             input logic p, input logic bm, input logic bs);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.dig  = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        e.p    = p;
        e.bm   = bm;
        e.bs   = bs;
        sb.push_back(e);
    endtask

    // Rising edge held high two cycles: must count exactly once.
    task automatic tick1();
        onehz_clk = 1'b1; step(); step();
        onehz_clk = 1'b0; step();
    endtask

    task automatic adj_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            twohz_clk = 1'b1; step(); step();
            twohz_clk = 1'b0; step();
        end
    endtask

    task automatic pulse_pause();
        pause_p = 1'b1; step();
        pause_p = 1'b0;
    endtask

    // Monitor: compare every due scoreboard entry away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones};
            checks++;
            if (got !== e.dig || paused !== e.p || blank_min !== e.bm || blank_sec !== e.bs) begin
                failures++;
                $display("FAIL %s: got %h:%h p=%b bm=%b bs=%b, expected %h:%h p=%b bm=%b bs=%b",
                         e.name, got[15:8], got[7:0], paused, blank_min, blank_sec,
                         e.dig[15:8], e.dig[7:0], e.p, e.bm, e.bs);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset, latency and basic count
        step(); step();
        expect_st("reset", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step(); step();
        onehz_clk = 1'b1;
        expect_st("t1_before_edge", 0, 0, 0, 0, 0);
        step();
        expect_st("t1_after_edge", 0, 1, 0, 0, 0);
        step();
        expect_st("t1_held_high", 0, 1, 0, 0, 0);
        onehz_clk = 1'b0;
        step();
        tick1(); tick1();
        expect_st("t1_count3", 0, 3, 0, 0, 0);

        // ---- 2: seconds carry and full wrap
        adj = 1'b1; sel = 1'b1; step();
        adj_ticks(56);
        adj = 1'b0; step();
        expect_st("t2_at_0059", 0, 59, 0, 0, 0);
        tick1();
        expect_st("t2_carry_0100", 1, 0, 0, 0, 0);
        adj = 1'b1; sel = 1'b0; step();
        adj_ticks(58);
        sel = 1'b1;
        adj_ticks(59);
        expect_st("t2_adj_5959", 59, 59, 0, 0, 0);
        adj = 1'b0; step();
        tick1();
        expect_st("t2_full_wrap", 0, 0, 0, 0, 0);

        // ---- 3: pause freezes count
        pulse_pause();
        expect_st("t3_paused", 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick1();
        expect_st("t3_frozen", 0, 0, 1, 0, 0);
        pulse_pause();
        expect_st("t3_resumed", 0, 0, 0, 0, 0);
        tick1();
        expect_st("t3_count_again", 0, 1, 0, 0, 0);

        // ---- 4: adjust fields and blanking
        adj = 1'b1; sel = 1'b1; step();
        adj_ticks(57);
        expect_st("t4_at_0058", 0, 58, 0, 0, 0);
        adj_ticks(3);
        expect_st("t4_sec_wrap_nocarry", 0, 1, 0, 0, 0);
        blink_clk = 1'b1; step(); step();
        expect_st("t4_blank_sec_on", 0, 1, 0, 0, 1);
        blink_clk = 1'b0; step(); step();
        expect_st("t4_blank_sec_off", 0, 1, 0, 0, 0);
        sel = 1'b0; blink_clk = 1'b1; step(); step();
        expect_st("t4_blank_min_on", 0, 1, 0, 1, 0);
        blink_clk = 1'b0; step(); step();
        adj_ticks(2);
        expect_st("t4_min_adj_0201", 2, 1, 0, 0, 0);
        adj = 1'b0; step();
        expect_st("t4_back_run", 2, 1, 0, 0, 0);

        // ---- 5: simultaneous events
        adj = 1'b1; sel = 1'b0; step();
        adj_ticks(58);
        sel = 1'b1;
        adj_ticks(9);
        adj = 1'b0; step();
        expect_st("t5_at_0010", 0, 10, 0, 0, 0);
        onehz_clk = 1'b1; pause_p = 1'b1; step();
        pause_p = 1'b0;
        expect_st("t5_pause_with_tick", 0, 11, 1, 0, 0);
        step(); onehz_clk = 1'b0; step();
        pulse_pause();
        expect_st("t5_resume", 0, 11, 0, 0, 0);
        onehz_clk = 1'b1; adj = 1'b1; step();
        expect_st("t5_adj_rise_drops_tick", 0, 11, 0, 0, 0);
        step(); onehz_clk = 1'b0; step();
        twohz_clk = 1'b1; adj = 1'b0; step();
        expect_st("t5_adj_fall_drops_tick2", 0, 11, 0, 0, 0);
        step(); twohz_clk = 1'b0; step();
        adj = 1'b1; step();
        pulse_pause();
        expect_st("t5_adjust_pause_toggle", 0, 11, 1, 0, 0);
        onehz_clk = 1'b1; adj = 1'b0; step();
        expect_st("t5_return_to_pause", 0, 11, 1, 0, 0);
        step(); onehz_clk = 1'b0; step();
        pulse_pause();
        expect_st("t5_pause_to_run", 0, 11, 0, 0, 0);

        // ---- 6: async reset mid-count
        adj = 1'b1; sel = 1'b0; step();
        adj_ticks(12);
        sel = 1'b1;
        adj_ticks(23);
        adj = 1'b0; step();
        expect_st("t6_at_1234", 12, 34, 0, 0, 0);
        step();
        rst = 1'b1; onehz_clk = 1'b1;
        expect_st("t6_async_clear", 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        step(); step();
        expect_st("t6_high_at_release", 0, 0, 0, 0, 0);
        onehz_clk = 1'b0; step();
        tick1();
        expect_st("t6_first_tick", 0, 1, 0, 0, 0);

        step(); step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
